// File: rtl/badhash_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : badhash_pkg
//  Description : Shared types and constant helpers for the badhash engine:
//                FSM state enum, generic rotate-left and the key schedule.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package badhash_pkg;

    // Widest data path the helper functions can handle.
    localparam int MAX_W = 64;

    // Key used by the original single-XOR hash block.
    localparam logic [31:0] LEGACY_KEY = 32'h1EA14969;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Rotate the low 'width' bits of x left by 'amount'. Bits above 'width'
    // are cleared in the result.
    function automatic logic [MAX_W-1:0] rotl(
        input logic [MAX_W-1:0] x,
        input int               width,
        input int               amount
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] res;
        int               a;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        a    = amount % width;
        res  = x & mask;
        // With a == 0 the right shift moves every valid bit out, leaving x.
        res  = ((res << a) | (res >> (width - a))) & mask;
        return res;
    endfunction

    // Round-k key: the base key rotated by k*rot within the data width.
    function automatic logic [MAX_W-1:0] key_schedule(
        input logic [MAX_W-1:0] key,
        input int               width,
        input int               k,
        input int               rot
    );
        return rotl(key, width, (k * rot) % width);
    endfunction

endpackage
`default_nettype wire

// File: rtl/badhash_round.sv
`default_nettype none
// ============================================================================
//  Module      : badhash_round
//  Description : One combinational hash round: XOR with the round key, then
//                rotate left by a fixed amount.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module badhash_round
    import badhash_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROT    = 1
) (
    input  logic [DATA_W-1:0] r_in,
    input  logic [DATA_W-1:0] key,
    output logic [DATA_W-1:0] r_out
);

    logic [DATA_W-1:0] w_mix;

    assign w_mix = r_in ^ key;

    // A zero rotate has no valid bit-slice form, so it is a plain pass-through.
    generate
        if (ROT == 0) begin : g_no_rot
            assign r_out = w_mix;
        end else begin : g_rot
            assign r_out = {w_mix[DATA_W-1-ROT:0], w_mix[DATA_W-1:DATA_W-ROT]};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/badhash_engine.sv
`default_nettype none
// ============================================================================
//  Module      : badhash_engine
//  Description : Iterated key-XOR/rotate hash over one word per transaction,
//                valid/ready on both sides, result held until accepted.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module badhash_engine
    import badhash_pkg::*;
#(
    parameter int          DATA_W = 32,
    parameter int          ROUNDS = 4,
    parameter int          ROT    = 1,
    parameter logic [31:0] KEY    = LEGACY_KEY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam int               CNT_W   = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int               TBL_N   = 1 << CNT_W;
    localparam logic [MAX_W-1:0] KEY_EXT = MAX_W'(KEY);
    localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(ROUNDS - 1);

    state_t            r_state;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_k;
    logic              r_valid;
    logic              r_busy;

    logic [DATA_W-1:0] w_key_tbl [TBL_N];
    logic [DATA_W-1:0] w_key;
    logic [DATA_W-1:0] w_round;

    // Round keys are elaboration-time constants; unused table slots (when
    // ROUNDS is not a power of two) are tied to zero and never selected.
    generate
        for (genvar gi = 0; gi < TBL_N; gi++) begin : g_key
            if (gi < ROUNDS) begin : g_used
                localparam logic [MAX_W-1:0] K_FULL =
                    key_schedule(KEY_EXT, DATA_W, gi, ROT);
                assign w_key_tbl[gi] = K_FULL[DATA_W-1:0];
            end else begin : g_pad
                assign w_key_tbl[gi] = '0;
            end
        end
    endgenerate

    assign w_key = w_key_tbl[r_k];

    badhash_round #(
        .DATA_W (DATA_W),
        .ROT    (ROT)
    ) u_round (
        .r_in   (r_data),
        .key    (w_key),
        .r_out  (w_round)
    );

    // Sequencer: load, iterate ROUNDS rounds, then hold the result until taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_k     <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_data  <= in_data;
                        r_k     <= '0;
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    r_data <= w_round;
                    r_k    <= r_k + 1'b1;
                    if (r_k == LAST_K) begin
                        r_state <= DONE;
                        r_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_valid <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: next word loads in the release cycle.
                            r_data  <= in_data;
                            r_k     <= '0;
                            r_state <= RUN;
                        end else begin
                            r_data  <= '0;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_data  <= '0;
                    r_k     <= '0;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // out_ready feeds in_ready directly so a finished result can be swapped
    // for a new word in the same cycle.
    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign out_valid = r_valid;
    assign out_data  = r_valid ? r_data : '0;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_badhash_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_badhash_engine
//  Description : Directed bench for badhash_engine. Three instances: defaults
//                (4 rounds, rotate 1), legacy (1 round, no rotate) and a
//                2-round key=1 variant. Expected values are hand-derived; with
//                ROT=1 and an even round count the keys cancel, so the default
//                hash of x is x rotated left by 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_badhash_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        busy      [3];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    always #5 clk = ~clk;

    badhash_engine u_dflt (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .busy(busy[0])
    );

    badhash_engine #(.ROUNDS(1), .ROT(0)) u_leg (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .busy(busy[1])
    );

    badhash_engine #(.ROUNDS(2), .ROT(1), .KEY(32'h00000001)) u_k1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .busy(busy[2])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after an accepting edge; returns the cycle index at which
    // out_valid is first seen (cycle 1 = first cycle after the accept).
    task automatic wait_valid(input int u, output int lat, output bit zero_ok);
        lat     = 1;
        zero_ok = 1'b1;
        @(negedge clk);
        while (!out_valid[u] && lat < 40) begin
            if (out_data[u] !== 32'h0) zero_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
    endtask

    // One complete transaction from IDLE with out_ready held high.
    task automatic hash_word(input int u, input logic [31:0] din, input logic [31:0] exp,
                             input int exp_lat, input string tag);
        int lat;
        bit zok;
        @(posedge clk); #1;
        in_valid[u]  = 1'b1;
        in_data[u]   = din;
        out_ready[u] = 1'b1;
        @(negedge clk);
        check({tag, "_accept_ready"}, in_ready[u], 1'b1);
        @(posedge clk); #1;
        in_valid[u] = 1'b0;
        in_data[u]  = 32'h0;
        wait_valid(u, lat, zok);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_zero_before_valid"}, zok, 1'b1);
        check({tag, "_data"}, out_data[u], exp);
        @(negedge clk);
        check({tag, "_valid_dropped"}, out_valid[u], 1'b0);
        check({tag, "_idle_busy"}, busy[u], 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [6];
        logic [31:0] b2b_in  [3];
        logic [31:0] b2b_exp [3];
        int          lat;
        bit          zok;
        bit          seen;
        int          nres;
        int          sent;
        bit          hs;

        tbl[0] = '{32'h00000000, 32'h00000000};
        tbl[1] = '{32'h12345678, 32'h23456781};
        tbl[2] = '{32'h80000001, 32'h00000018};
        tbl[3] = '{32'hF0000000, 32'h0000000F};
        tbl[4] = '{32'hDEADBEEF, 32'hEADBEEFD};
        tbl[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF};
        b2b_in  = '{32'h12345678, 32'h80000001, 32'hF0000000};
        b2b_exp = '{32'h23456781, 32'h00000018, 32'h0000000F};

        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            in_valid[u]  = 1'b0;
            in_data[u]   = 32'h0;
            out_ready[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_in_ready_%0d", u),  in_ready[u],  1'b1);
            check($sformatf("rst_out_valid_%0d", u), out_valid[u], 1'b0);
            check($sformatf("rst_out_data_%0d", u),  out_data[u],  32'h0);
            check($sformatf("rst_busy_%0d", u),      busy[u],      1'b0);
        end

        // Legacy single-XOR behaviour and the 2-round key=1 case.
        hash_word(1, 32'h00000000, 32'h1EA14969, 2, "leg_zero");
        hash_word(1, 32'hFFFFFFFF, 32'hE15EB696, 2, "leg_ones");
        hash_word(2, 32'h80000000, 32'h00000002, 3, "k1_msb");

        // Default configuration vector table.
        for (int i = 0; i < 6; i++)
            hash_word(0, tbl[i].din, tbl[i].dout, 5, $sformatf("tbl%0d", i));

        // Backpressure: result must hold for 10 cycles while out_ready is low.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 32'h12345678; out_ready[0] = 1'b0;
        @(negedge clk);
        check("bp_accept", in_ready[0], 1'b1);
        @(posedge clk); #1;
        in_data[0] = 32'hAAAA5555;
        wait_valid(0, lat, zok);
        check("bp_latency", lat, 5);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("bp_valid_%0d", i), out_valid[0], 1'b1);
            check($sformatf("bp_data_%0d", i),  out_data[0],  32'h23456781);
            check($sformatf("bp_ready_%0d", i), in_ready[0],  1'b0);
            check($sformatf("bp_busy_%0d", i),  busy[0],      1'b1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0; out_ready[0] = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready[0], 1'b1);
        check("bp_release_data", out_data[0], 32'h23456781);
        @(negedge clk);
        check("bp_after_valid", out_valid[0], 1'b0);
        check("bp_after_busy", busy[0], 1'b0);
        check("bp_after_ready", in_ready[0], 1'b1);

        // Back-to-back: three words, results every 5 cycles in order.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = b2b_in[0]; out_ready[0] = 1'b1;
        nres = 0;
        sent = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c <= 15)
                check($sformatf("b2b_in_ready_c%0d", c), in_ready[0], (c % 5 == 0));
            if (out_valid[0]) begin
                if (nres < 3) begin
                    check($sformatf("b2b_data_%0d", nres), out_data[0], b2b_exp[nres]);
                    check($sformatf("b2b_cycle_%0d", nres), c, 5 * (nres + 1));
                end
                nres++;
            end
            hs = in_valid[0] & in_ready[0];
            @(posedge clk); #1;
            if (hs) begin
                sent++;
                if (sent < 3) in_data[0] = b2b_in[sent];
                else          in_valid[0] = 1'b0;
            end
        end
        check("b2b_result_count", nres, 3);

        // Reset during the second RUN cycle discards the word.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 32'hDEADBEEF; out_ready[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("mrst_in_ready", in_ready[0], 1'b1);
        check("mrst_out_valid", out_valid[0], 1'b0);
        check("mrst_out_data", out_data[0], 32'h0);
        check("mrst_busy", busy[0], 1'b0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("mrst_no_stale_result", seen, 1'b0);
        hash_word(0, 32'h00000001, 32'h00000010, 5, "mrst_next1");
        hash_word(0, 32'hDEADBEEF, 32'hEADBEEFD, 5, "mrst_next2");

        // in_valid during RUN is ignored until the engine is ready again.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; in_data[0] = 32'h80000001; out_ready[0] = 1'b0;
        @(negedge clk);
        check("ign_accept", in_ready[0], 1'b1);
        @(posedge clk); #1;
        in_data[0] = 32'h0F000000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("ign_run_ready_%0d", i), in_ready[0], 1'b0);
            check($sformatf("ign_run_busy_%0d", i), busy[0], 1'b1);
            check($sformatf("ign_run_valid_%0d", i), out_valid[0], 1'b0);
        end
        @(negedge clk);
        check("ign_done_valid", out_valid[0], 1'b1);
        check("ign_done_data", out_data[0], 32'h00000018);
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        @(negedge clk);
        check("ign_release_ready", in_ready[0], 1'b1);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        wait_valid(0, lat, zok);
        check("ign_second_latency", lat, 5);
        check("ign_second_data", out_data[0], 32'hF0000000);
        @(negedge clk);
        check("ign_final_idle", busy[0], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/badhash_engine.md
# badhash_engine

Parametrised successor to the single-XOR hash block. It hashes one DATA_W-bit word per transaction through ROUNDS iterated rounds of key-XOR and rotate. Both sides use valid/ready handshakes, and the result is held until the consumer accepts it. It sits between the host-side input register slice and the result bus.

## Interface
- DATA_W, 32, data and key width (≥ 2)
- ROUNDS, 4, number of hash rounds (≥ 1)
- ROT, 1, per-round rotate-left amount (0 ≤ ROT < DATA_W)
- KEY, 32'h1EA14969, round-0 key, truncated/zero-extended to DATA_W
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  input word present
- in_ready  out  1  engine accepts a word this cycle
- in_data  in  DATA_W  word to hash
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- out_data  out  DATA_W  hash result; zero whenever out_valid=0
- busy  out  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. Round counter k has width max(1, clog2(ROUNDS)).
- Key schedule: key_k = rotl(KEY, (k*ROT) mod DATA_W).
- Round function: r_{k+1} = rotl(r_k ^ key_k, ROT); r_0 = in_data; result = r_ROUNDS.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready to in_ready and is intended.
- IDLE:
  - in_valid & in_ready: load reg ← in_data, k ← 0, go to RUN.
  - Otherwise stay in IDLE.
- RUN:
  - Each cycle: reg ← round(reg, key_k), k ← k+1.
  - After the round with k=ROUNDS-1, go to DONE.
  - in_valid is ignored.
- DONE:
  - out_valid=1, out_data=reg.
  - out_ready & in_valid: load the new word and go to RUN (back-to-back).
  - out_ready & !in_valid: go to IDLE, reg ← 0.
  - !out_ready: hold state and data; stable-while-valid rule.
- reset (any state, including mid-RUN): state ← IDLE, reg ← 0, k ← 0. Any in-flight word is discarded.
- Reset values: in_ready=1, out_valid=0, out_data=0, busy=0.
- ROT=0, ROUNDS=1 reduces to result = in_data ^ KEY, the legacy behaviour.

## Timing
- Handshake at cycle 0 → RUN in cycles 1..ROUNDS → out_valid=1 from cycle ROUNDS+1.
- Minimum latency is ROUNDS+1 cycles.
- Sustained throughput: one word per ROUNDS+1 cycles when out_ready is held high and in_valid is continuous.
- out_valid falls on the cycle after the out handshake unless a new word was accepted. If one was, out_valid is low for exactly ROUNDS cycles.
- busy is registered from the state; no combinational dependence on inputs.

## Structure
- Package badhash_pkg:
  - state enum (IDLE/RUN/DONE)
  - rotl function (DATA_W, amount)
  - key_schedule function
  - LEGACY_KEY constant 32'h1EA14969
- Sub-module badhash_round: purely combinational, ports r_in, key, r_out, parameters DATA_W and ROT. It is instantiated once; the FSM iterates it.
- FSM, counter and result register live in badhash_engine.

## Test plan
- Legacy mode, ROUNDS=1, ROT=0, defaults otherwise:
  - in 32'h00000000 → out 32'h1EA14969.
  - in 32'hFFFFFFFF → out 32'hE15EB696.
  - out_valid appears 2 cycles after the accept.
- ROUNDS=2, ROT=1, KEY=1, in 32'h80000000:
  - r1 = 32'h00000003, r2 = 32'h00000002.
  - out_valid at cycle 3.
  - out_data=0 in every cycle before that.
- Backpressure: hold out_ready=0 for 10 cycles in DONE.
  - out_valid and out_data stay stable; in_ready=0; busy=1.
  - Release → one transfer, then IDLE.
- Back-to-back: in_valid and out_ready held high with 3 words.
  - Results come every ROUNDS+1 cycles, in order.
  - in_ready pulses only in the DONE/out_ready cycles (and the first IDLE cycle).
- Reset mid-RUN (cycle 2 of 4), defaults:
  - Next cycle: in_ready=1, out_valid=0, out_data=0, busy=0.
  - A subsequent word hashes correctly with no residue from the aborted one.
- in_valid asserted during RUN is ignored; the word is accepted only once in_ready=1.
